// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge
// Brief    : Merges the core's fetch and data SRAM-like ports onto one AXI3
//            master with a single outstanding single-beat transaction.
// Revision : 1.0
// ============================================================================
module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        src_q, src_d;              // 1 = data port owns the transaction
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    // Responses are routed by the latched source, so the read id is unused.
    logic        w_unused_rid;
    assign w_unused_rid = ^rid;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        bready       = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_addr_ok = data_req;
                inst_addr_ok = inst_req & ~data_req;
                if (data_req) begin
                    src_d   = 1'b1;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    wstrb_d = data_wstrb;
                    if (data_wr) begin
                        state_d   = S_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = S_AR;
                    end
                end else if (inst_req) begin
                    src_d   = 1'b0;
                    addr_d  = inst_addr;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_d = S_IDLE;
                    if (src_q) begin
                        data_data_ok = 1'b1;
                        data_rdata_d = rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata_d = rdata;
                    end
                end
            end
            S_W: begin
                // Address and data channels retire independently, in any order.
                if (awready) begin
                    awvalid_d = 1'b0;
                end
                if (wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Read data is forwarded in the pulse cycle and held afterwards.
    assign inst_rdata = inst_rdata_d;
    assign data_rdata = data_rdata_d;
    assign arid       = {3'b000, src_q};
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign awvalid    = awvalid_q;
    assign wvalid     = wvalid_q;

endmodule
`default_nettype wire
